// File: rtl/ball_motion_engine.sv
// Pong ball physics: one position update per video frame, with wall and
// paddle bounces, miss detection and a serve delay at the centre.
module ball_motion_engine #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_VEL     = 2,
    parameter int WALL_X       = 32,
    parameter int PADDLE_X_L   = 600,
    parameter int PADDLE_H     = 72,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_25MHZ,
    input  logic [9:0] contador_x,
    input  logic [9:0] contador_y,
    input  logic [9:0] paddle_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [7:0] hit_count,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       in_play
);

    localparam logic [9:0]  CX  = 10'(H_ACTIVE / 2 - BALL_SIZE / 2);
    localparam logic [9:0]  CY  = 10'(V_ACTIVE / 2 - BALL_SIZE / 2);
    localparam logic [10:0] SZ  = 11'(BALL_SIZE);
    localparam logic [10:0] VEL = 11'(BALL_VEL);
    localparam logic [10:0] VA  = 11'(V_ACTIVE);
    localparam logic [10:0] HA  = 11'(H_ACTIVE);
    localparam logic [10:0] WX  = 11'(WALL_X);
    localparam logic [10:0] PXL = 11'(PADDLE_X_L);
    localparam logic [10:0] PH  = 11'(PADDLE_H);
    localparam logic [7:0]  SRV_LAST = 8'(SERVE_FRAMES - 1);

    typedef enum logic {SERVE, PLAY} state_t;

    state_t     state_q, state_d;
    logic [7:0] serve_cnt_q, serve_cnt_d;
    logic [9:0] ball_x_q, ball_x_d;
    logic [9:0] ball_y_q, ball_y_d;
    logic       dx_left_q, dx_left_d;
    logic       dy_up_q, dy_up_d;
    logic [7:0] hit_q, hit_d;
    logic       hit_pulse_q, hit_pulse_d;
    logic       miss_pulse_q, miss_pulse_d;

    logic        frame_tick;
    logic [10:0] x11, y11, py11, x_r;
    logic        overlap;

    assign frame_tick = CLK_25MHZ && (contador_x == 10'd0)
                        && (contador_y == 10'(V_ACTIVE));

    assign x11     = {1'b0, ball_x_q};
    assign y11     = {1'b0, ball_y_q};
    assign py11    = {1'b0, paddle_y};
    assign x_r     = x11 + SZ;
    assign overlap = (y11 + SZ > py11) && (y11 < py11 + PH);

    always_comb begin
        state_d      = state_q;
        serve_cnt_d  = serve_cnt_q;
        ball_x_d     = ball_x_q;
        ball_y_d     = ball_y_q;
        dx_left_d    = dx_left_q;
        dy_up_d      = dy_up_q;
        hit_d        = hit_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        if (frame_tick) begin
            unique case (state_q)
                SERVE: begin
                    if (serve_cnt_q == SRV_LAST) begin
                        state_d     = PLAY;
                        serve_cnt_d = 8'd0;
                    end else begin
                        serve_cnt_d = serve_cnt_q + 8'd1;
                    end
                end
                PLAY: begin
                    if (!dy_up_q && (y11 + SZ + VEL >= VA)) begin
                        ball_y_d = 10'(VA - SZ);
                        dy_up_d  = 1'b1;
                    end else if (dy_up_q && (y11 <= VEL)) begin
                        ball_y_d = 10'd0;
                        dy_up_d  = 1'b0;
                    end else if (dy_up_q) begin
                        ball_y_d = 10'(y11 - VEL);
                    end else begin
                        ball_y_d = 10'(y11 + VEL);
                    end

                    if (dx_left_q) begin
                        if (x11 <= WX + VEL) begin
                            ball_x_d  = 10'(WX);
                            dx_left_d = 1'b0;
                        end else begin
                            ball_x_d = 10'(x11 - VEL);
                        end
                    end else if ((x_r <= PXL) && (x_r + VEL >= PXL)
                                 && overlap) begin
                        ball_x_d    = 10'(PXL - SZ);
                        dx_left_d   = 1'b1;
                        hit_pulse_d = 1'b1;
                        hit_d = (hit_q == 8'hFF) ? hit_q : hit_q + 8'd1;
                    end else if (x_r + VEL >= HA) begin
                        // Miss discards the vertical result, keeps directions.
                        miss_pulse_d = 1'b1;
                        hit_d        = 8'd0;
                        state_d      = SERVE;
                        ball_x_d     = CX;
                        ball_y_d     = CY;
                        dy_up_d      = dy_up_q;
                    end else begin
                        ball_x_d = 10'(x11 + VEL);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= SERVE;
            serve_cnt_q  <= 8'd0;
            ball_x_q     <= CX;
            ball_y_q     <= CY;
            dx_left_q    <= 1'b0;
            dy_up_q      <= 1'b0;
            hit_q        <= 8'd0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            serve_cnt_q  <= serve_cnt_d;
            ball_x_q     <= ball_x_d;
            ball_y_q     <= ball_y_d;
            dx_left_q    <= dx_left_d;
            dy_up_q      <= dy_up_d;
            hit_q        <= hit_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
        end
    end

    assign ball_x     = ball_x_q;
    assign ball_y     = ball_y_q;
    assign hit_count  = hit_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;
    assign in_play    = (state_q == PLAY);

endmodule
